// File: rtl/uart_1318_pkg.sv
// Shared UART definitions: clock defaults, width helper, TX state encoding and frame length.
package uart_1318_pkg;

  localparam int unsigned CLK_FREQ_DEF  = 50_000_000;
  localparam int unsigned BAUD_RATE_DEF = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Cycles from the first start-bit cycle to the end of the last stop bit.
  function automatic int unsigned frame_len(input int unsigned div, input int unsigned parity,
                                            input int unsigned stops);
    return div * (10 + parity + stops - 1);
  endfunction

endpackage

// File: rtl/uart_baud_gen_1318.sv
// Bit-period timer: counts 0..DIV-1 and pulses tick_c on the last count of each bit.
module uart_baud_gen_1318
  import uart_1318_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick_c = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || tick_c) count <= '0;
    else                      count <= count + CW'(1);
  end

endmodule

// File: rtl/uart_tx_1318.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
module uart_tx_1318
  import uart_1318_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
  parameter int unsigned BAUD_RATE  = BAUD_RATE_DEF,
  parameter int unsigned Parity_Bit = 1,
  parameter int unsigned Stop_Bit   = 1
) (
  input  logic       Clk_TX,
  input  logic       Reset_T,
  input  logic [7:0] DATA_TX_In,
  input  logic       Valid_TX_In,
  output logic       Ready_TX_Out,
  output logic       DATA_TX_Out,
  output logic       Busy_TX
);

  localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;
  localparam bit PAR_EN = (Parity_Bit != 0);
  localparam logic LAST_STOP = 1'(Stop_Bit - 1);

  if (Stop_Bit != 1 && Stop_Bit != 2) begin : g_bad_stop
    $error("uart_tx_1318: Stop_Bit must be 1 or 2");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_1318: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (Parity_Bit > 1) begin : g_bad_par
    $error("uart_tx_1318: Parity_Bit must be 0 or 1");
  end

  tx_state_e  state, state_n;
  logic [7:0] shift, shift_n;
  logic [2:0] idx, idx_n;
  logic       stop_cnt, stop_cnt_n;
  logic       par, par_n;
  logic       line_n, ready_n, busy_n;
  logic       accept_c, tick_c;

  assign accept_c = Valid_TX_In && Ready_TX_Out;

  uart_baud_gen_1318 #(.DIV(DIV)) u_baud (
    .clk    (Clk_TX),
    .rst    (Reset_T),
    .clr    (accept_c),
    .tick_c (tick_c)
  );

  always_ff @(posedge Clk_TX) begin
    if (Reset_T) begin
      state        <= ST_IDLE;
      shift        <= '1;
      idx          <= '0;
      stop_cnt     <= 1'b0;
      par          <= 1'b0;
      DATA_TX_Out  <= 1'b1;
      Ready_TX_Out <= 1'b1;
      Busy_TX      <= 1'b0;
    end else begin
      state        <= state_n;
      shift        <= shift_n;
      idx          <= idx_n;
      stop_cnt     <= stop_cnt_n;
      par          <= par_n;
      DATA_TX_Out  <= line_n;
      Ready_TX_Out <= ready_n;
      Busy_TX      <= busy_n;
    end
  end

  // Next-state logic; the line value for each bit is loaded on the edge that starts it.
  always_comb begin
    state_n    = state;
    shift_n    = shift;
    idx_n      = idx;
    stop_cnt_n = stop_cnt;
    par_n      = par;
    line_n     = DATA_TX_Out;
    ready_n    = Ready_TX_Out;
    busy_n     = Busy_TX;
    unique case (state)
      ST_IDLE: begin
        line_n = 1'b1;
        if (accept_c) begin
          state_n    = ST_START;
          shift_n    = DATA_TX_In;
          par_n      = ^DATA_TX_In;
          idx_n      = '0;
          stop_cnt_n = 1'b0;
          line_n     = 1'b0;
          ready_n    = 1'b0;
          busy_n     = 1'b1;
        end
      end
      ST_START: begin
        if (tick_c) begin
          state_n = ST_DATA;
          line_n  = shift[0];
          shift_n = {1'b1, shift[7:1]};
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          if (idx == 3'd7) begin
            if (PAR_EN) begin
              state_n = ST_PARITY;
              line_n  = par;
            end else begin
              state_n = ST_STOP;
              line_n  = 1'b1;
            end
          end else begin
            idx_n   = idx + 3'd1;
            line_n  = shift[0];
            shift_n = {1'b1, shift[7:1]};
          end
        end
      end
      ST_PARITY: begin
        if (tick_c) begin
          state_n = ST_STOP;
          line_n  = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick_c) begin
          if (stop_cnt == LAST_STOP) begin
            state_n = ST_IDLE;
            line_n  = 1'b1;
            ready_n = 1'b1;
            busy_n  = 1'b0;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        line_n  = 1'b1;
        ready_n = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_1318.sv
// Self-checking bench for uart_tx_1318: four configurations checked against a cycle-level scoreboard.
module tb_uart_tx_1318;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: DIV=4 parity stop1; 1: DIV=4 no parity; 2: DIV=4 parity stop2; 3: defaults.
  logic [3:0] rst   = 4'h0;
  logic [3:0] valid = 4'h0;
  logic [3:0] ready, line, busy;
  logic [7:0] data [4];

  int errors = 0;
  int checks = 0;

  logic       exp_q[$];
  logic [7:0] exp_byte_q[$];

  uart_tx_1318 #(.CLK_FREQ(8), .BAUD_RATE(2), .Parity_Bit(1), .Stop_Bit(1)) u_p1 (
    .Clk_TX(clk), .Reset_T(rst[0]), .DATA_TX_In(data[0]), .Valid_TX_In(valid[0]),
    .Ready_TX_Out(ready[0]), .DATA_TX_Out(line[0]), .Busy_TX(busy[0]));
  uart_tx_1318 #(.CLK_FREQ(8), .BAUD_RATE(2), .Parity_Bit(0), .Stop_Bit(1)) u_p0 (
    .Clk_TX(clk), .Reset_T(rst[1]), .DATA_TX_In(data[1]), .Valid_TX_In(valid[1]),
    .Ready_TX_Out(ready[1]), .DATA_TX_Out(line[1]), .Busy_TX(busy[1]));
  uart_tx_1318 #(.CLK_FREQ(8), .BAUD_RATE(2), .Parity_Bit(1), .Stop_Bit(2)) u_s2 (
    .Clk_TX(clk), .Reset_T(rst[2]), .DATA_TX_In(data[2]), .Valid_TX_In(valid[2]),
    .Ready_TX_Out(ready[2]), .DATA_TX_Out(line[2]), .Busy_TX(busy[2]));
  uart_tx_1318 u_def (
    .Clk_TX(clk), .Reset_T(rst[3]), .DATA_TX_In(data[3]), .Valid_TX_In(valid[3]),
    .Ready_TX_Out(ready[3]), .DATA_TX_Out(line[3]), .Busy_TX(busy[3]));

  function automatic int unsigned div_of(input int s);
    return (s == 3) ? 434 : 4;
  endfunction
  function automatic int unsigned par_of(input int s);
    return (s == 1) ? 0 : 1;
  endfunction
  function automatic int unsigned stops_of(input int s);
    return (s == 2) ? 2 : 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level per cycle for one frame.
  task automatic push_frame(input int s, input logic [7:0] b);
    logic lv[$];
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(b[i]);
    if (par_of(s) != 0) lv.push_back(^b);
    for (int i = 0; i < int'(stops_of(s)); i++) lv.push_back(1'b1);
    foreach (lv[k]) for (int unsigned j = 0; j < div_of(s); j++) exp_q.push_back(lv[k]);
  endtask

  task automatic accept(input int s, input logic [7:0] b, input bit hold);
    checks++;
    if (ready[s] !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready inst%0d: ready=%b expected 1", s, ready[s]);
    end
    if (s == 3) exp_byte_q.push_back(b);
    else push_frame(s, b);
    data[s]  = b;
    valid[s] = 1'b1;
    step();
    if (!hold) valid[s] = 1'b0;
  endtask

  // Pops the scoreboard one cycle at a time; optional busy-time poke or mid-frame reset.
  task automatic check_frame(input int s, input string name, input int poke, input int abort_at);
    int c;
    logic e;
    c = 1;
    checks++;
    if (busy[s] !== 1'b1 || ready[s] !== 1'b0) begin
      errors++;
      $display("FAIL %s first_cycle: busy=%b ready=%b expected busy=1 ready=0", name, busy[s], ready[s]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (line[s] !== e) begin
        errors++;
        $display("FAIL %s line cycle %0d: got %b expected %b", name, c, line[s], e);
      end
      if (exp_q.size() == 0) begin
        checks++;
        if (busy[s] !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_last_cycle: got %b expected 1", name, busy[s]);
        end
      end
      if (c == poke) begin
        valid[s] = 1'b1;
        data[s]  = 8'h3C;
      end else if (c == poke + 1) begin
        valid[s] = 1'b0;
        data[s]  = 8'hFF;
      end
      if (c == abort_at) begin
        rst[s] = 1'b1;
        step();
        rst[s] = 1'b0;
        checks++;
        if (line[s] !== 1'b1 || ready[s] !== 1'b1 || busy[s] !== 1'b0) begin
          errors++;
          $display("FAIL %s after_reset: line=%b ready=%b busy=%b expected 1 1 0",
                   name, line[s], ready[s], busy[s]);
        end
        exp_q.delete();
        return;
      end
      step();
      c++;
    end
    checks++;
    if (ready[s] !== 1'b1 || busy[s] !== 1'b0 || line[s] !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_end cycle %0d: ready=%b busy=%b line=%b expected 1 0 1",
               name, c, ready[s], busy[s], line[s]);
    end
  endtask

  // Bench-side receiver: mid-bit sampling plus start-run width measurement.
  task automatic rx_check(input int s);
    int unsigned div, flen, low_run, exp_low;
    bit low_done;
    logic [11:0] bits;
    logic [7:0] rx, eb;
    logic lv[$];
    div = div_of(s);
    flen = div * (10 + par_of(s) + stops_of(s) - 1);
    low_run = 0;
    low_done = 1'b0;
    bits = '1;
    for (int unsigned c = 1; c <= flen; c++) begin
      if (!low_done) begin
        if (line[s] === 1'b0) low_run++;
        else low_done = 1'b1;
      end
      if ((c - 1) % div == div / 2) bits[(c - 1) / div] = line[s];
      step();
    end
    checks++;
    if (ready[s] !== 1'b1 || busy[s] !== 1'b0) begin
      errors++;
      $display("FAIL rx_frame_end: ready=%b busy=%b expected 1 0", ready[s], busy[s]);
    end
    eb = exp_byte_q.pop_front();
    rx = bits[8:1];
    checks++;
    if (rx !== eb) begin
      errors++;
      $display("FAIL rx_byte: got %h expected %h", rx, eb);
    end
    checks++;
    if (bits[0] !== 1'b0 || bits[9] !== ^eb || bits[10] !== 1'b1) begin
      errors++;
      $display("FAIL rx_framing byte %h: start=%b parity=%b stop=%b expected 0 %b 1",
               eb, bits[0], bits[9], bits[10], ^eb);
    end
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(eb[i]);
    lv.push_back(^eb);
    exp_low = 0;
    foreach (lv[k]) begin
      if (lv[k] == 1'b0 && exp_low == k * div) exp_low += div;
    end
    checks++;
    if (low_run != exp_low) begin
      errors++;
      $display("FAIL rx_low_width byte %h: got %0d cycles expected %0d", eb, low_run, exp_low);
    end
  endtask

  task automatic test_reset();
    rst = 4'hF;
    valid = 4'h0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (line[i] !== 1'b1) begin errors++; $display("FAIL reset_line inst%0d: got %b expected 1", i, line[i]); end
      checks++;
      if (ready[i] !== 1'b1) begin errors++; $display("FAIL reset_ready inst%0d: got %b expected 1", i, ready[i]); end
      checks++;
      if (busy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy inst%0d: got %b expected 0", i, busy[i]); end
    end
    rst = 4'h0;
    step();
  endtask

  task automatic test_frames();
    accept(0, 8'hA5, 1'b0);
    check_frame(0, "p1_a5", -1, -1);
    accept(0, 8'h01, 1'b0);
    check_frame(0, "p1_01", -1, -1);
    accept(1, 8'hA5, 1'b0);
    check_frame(1, "p0_a5", -1, -1);
    accept(1, 8'h80, 1'b0);
    check_frame(1, "p0_80", -1, -1);
  endtask

  task automatic test_back_to_back();
    int unsigned t1, t2;
    accept(2, 8'hFF, 1'b1);
    t1 = cyc;
    check_frame(2, "s2_first", -1, -1);
    accept(2, 8'hFF, 1'b1);
    t2 = cyc;
    valid[2] = 1'b0;
    checks++;
    if (t2 - t1 != 49) begin
      errors++;
      $display("FAIL b2b_gap: got %0d cycles expected 49", t2 - t1);
    end
    check_frame(2, "s2_second", -1, -1);
  endtask

  task automatic test_ignore_busy();
    accept(0, 8'hC3, 1'b0);
    check_frame(0, "ignore", 10, -1);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (line[0] !== 1'b1 || ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL ignore_idle cycle %0d: line=%b ready=%b expected 1 1", i, line[0], ready[0]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    accept(0, 8'hA5, 1'b0);
    check_frame(0, "abort", -1, 18);
    accept(0, 8'h3C, 1'b0);
    check_frame(0, "after_abort", -1, -1);
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [3];
    bytes[0] = 8'h00;
    bytes[1] = 8'h55;
    bytes[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      accept(3, bytes[i], 1'b0);
      rx_check(3);
    end
  endtask

  initial begin
    #(500_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_1318.md
Name: uart_tx_1318

Overview:
UART transmitter that serialises bytes onto the RS-232 TX line. It is the counterpart of the receiver stage, and its line output can loop back directly into the receiver input for self-test. A Valid/Ready handshake accepts a byte. The block emits start bit, 8 data bits LSB first, optional even parity, then 1 or 2 stop bits, all at a fixed baud rate derived from the system clock.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate; DIV = CLK_FREQ/BAUD_RATE (integer division, 434 at defaults)
Parity_Bit, 1, 1 = even parity bit appended after data; 0 = no parity
Stop_Bit, 1, number of stop bits; legal values 1 or 2

Ports:
Clk_TX  input  1  transmitter clock; the single clock for the block
Reset_T  input  1  synchronous, active-high reset
DATA_TX_In  input  8  byte to transmit; sampled only on the accept cycle
Valid_TX_In  input  1  producer has a byte on DATA_TX_In
Ready_TX_Out  output  1  block can accept a byte this cycle
DATA_TX_Out  output  1  serial TX line; idle high; registered output
Busy_TX  output  1  high from the cycle after accept until the end of the last stop bit

Behaviour:
- Reset (Reset_T=1 at a clock edge): state=IDLE, DATA_TX_Out=1, Ready_TX_Out=1, Busy_TX=0, baud counter=0, shift register=all ones. Reset overrides everything.
- Reset mid-frame aborts the frame. The line is high on the cycle after the reset edge. No partial resume occurs.
- Accept: the block accepts a byte when Valid_TX_In && Ready_TX_Out at a rising edge. It latches the byte and, if enabled, parity = ^DATA_TX_In.
- In the accept cycle itself, Ready_TX_Out drops to 0 and Busy_TX rises to 1. Both take effect on the next cycle.
- Valid_TX_In while Ready_TX_Out=0 is ignored; the byte is neither queued nor lost-flagged. Changes on DATA_TX_In after accept do not affect the frame in flight.
- States: IDLE -> START -> DATA -> PARITY (skipped when Parity_Bit=0) -> STOP -> IDLE.
- Baud counter: runs 0..DIV-1 and is cleared on accept. A bit ends when the counter reaches DIV-1, and the counter then wraps to 0. Every bit lasts exactly DIV cycles.
- Counter width is clog2(DIV), minimum 1.
- START: DATA_TX_Out=0 for DIV cycles, starting the cycle after accept.
- DATA: 8 bits, LSB first. A 3-bit index counts 0..7; DATA is left after index 7 ends.
- PARITY: DATA_TX_Out = latched even parity, for DIV cycles.
- STOP: DATA_TX_Out=1 for Stop_Bit*DIV cycles. The stop count is tracked by a counter, not by extra states.
- Frame length: DIV*(10+Parity_Bit+(Stop_Bit-1)) cycles from the first start-bit cycle to the end of the last stop bit.
- Return to IDLE on the last stop cycle: Busy_TX=0 and Ready_TX_Out=1 on the following cycle. IDLE lasts at least 1 cycle with the line high.
- Back-to-back frames therefore repeat every frame length + 1 cycles.
- Latency: 1 clock from the accept edge to the falling edge of the start bit on DATA_TX_Out.
- DATA_TX_Out is driven straight from a flop, with no combinational path from inputs to the line.
- Illegal parameters (Stop_Bit not 1 or 2, or DIV < 2) trigger an elaboration-time error.

Decomposition:
- Shared package uart_1318_pkg:
  - CLK_FREQ and BAUD_RATE defaults
  - clog2 function
  - TX state encoding (IDLE/START/DATA/PARITY/STOP)
  - frame-length helper function, reused by the receiver and the bench
- One sub-module, uart_baud_gen_1318: counter 0..DIV-1 with synchronous clear input and a 1-cycle tick output at DIV-1. It is written so the receiver can reuse it.

Test Plan:
- Reset, then CLK_FREQ=8, BAUD_RATE=2 (DIV=4), Parity_Bit=1, Stop_Bit=1, send 0xA5 -> line reads 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1. Each level lasts 4 cycles, 44 cycles total. Busy_TX is high for 44 cycles; Ready_TX_Out returns on cycle 45.
- Same config, send 0x01 -> parity bit = 1. With Parity_Bit=0 the frame is 40 cycles and no parity slot exists.
- Stop_Bit=2, send 0xFF -> stop high for 8 cycles; frame is 48 cycles. Valid_TX_In held high continuously gives a 2nd start bit exactly 49 cycles after the 1st.
- Pulse Valid_TX_In with 0x3C while busy, then change DATA_TX_In mid-frame -> the ignored byte is never sent and the in-flight byte is unchanged.
- Assert Reset_T during data bit 3 -> line goes high the next cycle, Ready_TX_Out=1, Busy_TX=0. A new byte sent afterwards is framed correctly.
- Defaults (DIV=434): loop DATA_TX_Out into the receiver and send 0x00, 0x55, 0xFF -> the receiver reports identical bytes. Each bit measures 434 cycles.
